// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache (8 lines x 4 bytes)
// with its miss-handling controller. Hits are served combinationally with no
// stall. A miss stalls the CPU, writes back a dirty victim, fetches the
// missing block, and then lets the held access complete as a hit.
module dcache_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // High during the first cycle after entering a state. Memory may not
    // have raised its busy flag yet at that edge, so completion is ignored.
    logic first_reg;

    // Cache arrays
    logic [31:0] data_reg  [0:7];
    logic [2:0]  tag_reg   [0:7];
    logic [7:0]  valid_reg;
    logic [7:0]  dirty_reg;

    // Address fields
    logic [2:0]  addr_tag;
    logic [2:0]  addr_index;
    logic [1:0]  addr_offset;
    assign addr_tag    = address[7:5];
    assign addr_index  = address[4:2];
    assign addr_offset = address[1:0];

    logic        access;
    logic        hit;
    logic        mem_done;
    logic [31:0] line_data;
    logic [7:0]  sel_byte;
    logic        fill_en;
    logic        store_en;

    assign access    = read | write;
    assign line_data = data_reg[addr_index];
    assign sel_byte  = line_data[{addr_offset, 3'b000} +: 8];
    assign hit       = valid_reg[addr_index] && (tag_reg[addr_index] == addr_tag);
    assign mem_done  = !first_reg && !mem_busywait;

    // State register and first-cycle flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            first_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            first_reg <= (state_next != state_reg);
        end
    end

    // Next-state logic and all outputs; everything here is combinational
    always_comb begin
        state_next    = state_reg;
        busywait      = 1'b0;
        readdata      = 8'd0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 6'd0;
        mem_writedata = 32'd0;
        fill_en       = 1'b0;
        store_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (access) begin
                    if (hit) begin
                        // A simultaneous READ and WRITE is handled as a store.
                        if (write) begin
                            store_en = 1'b1;
                        end else begin
                            readdata = sel_byte;
                        end
                    end else begin
                        busywait = 1'b1;
                        if (valid_reg[addr_index] && dirty_reg[addr_index]) begin
                            state_next = WRITEBACK;
                        end else begin
                            state_next = FETCH;
                        end
                    end
                end
            end
            WRITEBACK: begin
                busywait      = 1'b1;
                mem_write     = 1'b1;
                mem_address   = {tag_reg[addr_index], addr_index};
                mem_writedata = line_data;
                if (mem_done) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                busywait    = 1'b1;
                mem_read    = 1'b1;
                mem_address = {addr_tag, addr_index};
                if (mem_done) begin
                    fill_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line fill on fetch completion, byte store on write hit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= 8'd0;
            dirty_reg <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                data_reg[i] <= 32'd0;
                tag_reg[i]  <= 3'd0;
            end
        end else if (fill_en) begin
            data_reg[addr_index]  <= mem_readdata;
            tag_reg[addr_index]   <= addr_tag;
            valid_reg[addr_index] <= 1'b1;
            dirty_reg[addr_index] <= 1'b0;
        end else if (store_en) begin
            data_reg[addr_index][{addr_offset, 3'b000} +: 8] <= writedata;
            dirty_reg[addr_index] <= 1'b1;
        end
    end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache plus its controller FSM, placed between the CPU datapath (driven by the control unit's READ/WRITE strobes and the ALU-computed address) and the 32-bit-block data memory. It serves byte hits with no stall. On a miss it raises BUSYWAIT to freeze the PC, writes back a dirty victim, fetches the missing block, and then completes the access as a hit.

## Interface
- No parameters. Geometry is fixed: 8 lines × 4 bytes. ADDRESS[7:5]=tag, [4:2]=index, [1:0]=byte offset.
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset
- READ  in  1  CPU load request; held while BUSYWAIT=1
- WRITE  in  1  CPU store request; held while BUSYWAIT=1
- ADDRESS  in  8  CPU byte address
- WRITEDATA  in  8  store byte
- READDATA  out  8  load byte
- BUSYWAIT  out  1  stall request to CPU/PC
- MEM_READ  out  1  block fetch request
- MEM_WRITE  out  1  block write-back request
- MEM_ADDRESS  out  6  block address {tag,index}
- MEM_WRITEDATA  out  32  victim block, byte0 in [7:0]
- MEM_READDATA  in  32  fetched block, byte0 in [7:0]
- MEM_BUSYWAIT  in  1  memory busy. Must be high by the first edge after a request rises.

## Operation
- Per-line storage: 32-bit data, 3-bit tag, valid bit, dirty bit.
- hit = valid[index] && tag[index]==ADDRESS[7:5], evaluated combinationally.
- Access = READ|WRITE. If READ and WRITE are both high, the access is treated as a WRITE; READDATA is then 0.
- States:
  - IDLE
    - No access: BUSYWAIT=0.
    - Read hit: READDATA = selected byte, combinational; BUSYWAIT=0.
    - Write hit: BUSYWAIT=0. On the next edge, the byte is written and dirty[index] is set.
    - Miss: BUSYWAIT=1 combinationally. Next state is WRITEBACK if the line is valid and dirty, otherwise FETCH.
  - WRITEBACK
    - MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=line data.
    - Exits to FETCH on completion.
  - FETCH
    - MEM_READ=1, MEM_ADDRESS={ADDRESS[7:5],index}.
    - On completion, at that same edge: data←MEM_READDATA, tag←ADDRESS[7:5], valid←1, dirty←0. Next state is IDLE.
- Completion: an edge in WRITEBACK or FETCH where MEM_BUSYWAIT=0, excluding the first edge after entering the state.
- BUSYWAIT=1 throughout WRITEBACK and FETCH.
- After FETCH returns to IDLE, the held access hits. BUSYWAIT falls in that cycle, and a pending store writes at the following edge (write-allocate).
- READDATA = 0 whenever there is no read hit in IDLE.
- MEM_READ and MEM_WRITE are never high together. Both are 0 in IDLE.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; all valid=0 and dirty=0.
  - BUSYWAIT=0 unless an access is presented (every access misses after reset).
  - MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0.
- Reset mid-miss: the request drops within the same time step and no line is updated. Any write-back in progress is lost by design.
- Hit latency: 0 stall cycles. Read data is valid in the request cycle; a store commits at the end of the request cycle.
- Memory model used for the latency figures: MEM_BUSYWAIT high for the first M cycles of a request, low in cycle M+1.
  - Clean miss: BUSYWAIT high for exactly M+2 cycles.
  - Dirty miss: BUSYWAIT high for exactly 2M+3 cycles.
- All outputs are functions of the state and the current inputs only. No output is registered apart from the state and the cache arrays.
- Changes to ADDRESS, READ or WRITE while BUSYWAIT=1 are a protocol violation. The controller completes FETCH for whatever ADDRESS shows at completion.

## Test plan
- Reset, then READ at address 0x14, with memory block 5 = 0xDDCCBBAA and M=5. Required: BUSYWAIT high for 7 cycles, MEM_READ with MEM_ADDRESS=0x05, then READDATA=0xAA and BUSYWAIT=0. No MEM_WRITE pulse.
- Immediately re-read 0x15, 0x16 and 0x17. Required: READDATA = 0xBB, 0xCC, 0xDD, each with zero stall cycles and no memory request.
- WRITE 0x5A to 0x16 (hit), then READ 0xB4, which has the same index and a different tag (M=5). Required:
  - store has no stall;
  - miss stalls 13 cycles;
  - MEM_WRITE with MEM_ADDRESS=0x05 and MEM_WRITEDATA=0xDD5ABBAA, then MEM_READ with MEM_ADDRESS=0x2D.
- WRITE 0x77 to 0x40 (clean miss, M=2). Required: 4 stall cycles, then byte 0 of line 0 = 0x77 with dirty=1. A following READ 0x40 returns 0x77 with no stall.
- Assert RESET low during cycle 3 of a FETCH. Required: MEM_READ=0 and BUSYWAIT=0 immediately. Once RESET is released, a re-read of the same address misses again.
- READ and WRITE high together to a hit address with WRITEDATA=0x11. Required: the byte is written, READDATA=0, and there is no stall.
